// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator and its consumers
// (pixel renderer, frame-synchronous game-state logic).
// Signals: pix_en (consumer -> generator), Hsync/Vsync, hc/vc raster counts, vidon, x/y
// active-area coordinates, line_end/frame_start strobes (generator -> consumer).
// master = timing generator, slave = consumer.
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             pix_en;
  logic             Hsync;
  logic             Vsync;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  logic             vidon;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_end;
  logic             frame_start;

  modport master (
    input  pix_en,
    output Hsync, Vsync, hc, vc, vidon, x, y, line_end, frame_start
  );

  modport slave (
    output pix_en,
    input  Hsync, Vsync, hc, vc, vidon, x, y, line_end, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator (sync, counters, active flag,
// active-area coordinates, line/frame strobes). Counters advance only on pix_en cycles.
// Ports: clk, rst (synchronous, active-high), bus (vga_timing_gen_if.master).
// Latency: decoded outputs are combinational from hc/vc by default; with VGA_OUT_REG_EN
// defined they are registered and lag hc/vc by exactly one pixel.
// Backpressure: none; pix_en is the only pacing input and all outputs hold between enables.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_START + V_ACTIVE);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;

  // Raster counters: vc steps only on the hc wrap so both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (bus.pix_en) begin
      if (hc == H_LAST_C) begin
        hc <= '0;
        vc <= (vc == V_LAST_C) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Decode of the current raster position.
  logic             hs_d;
  logic             vs_d;
  logic             vid_d;
  logic [CNT_W-1:0] x_d;
  logic [CNT_W-1:0] y_d;
  logic             line_end_d;
  logic             frame_start_d;

  always_comb begin
    hs_d  = (hc < H_SYNC_C) ? HS_ON : ~HS_ON;
    vs_d  = (vc < V_SYNC_C) ? VS_ON : ~VS_ON;
    vid_d = (hc >= H_START_C) && (hc < H_END_C) &&
            (vc >= V_START_C) && (vc < V_END_C);
    x_d   = vid_d ? (hc - H_START_C) : '0;
    y_d   = vid_d ? (vc - V_START_C) : '0;
    // Strobes are qualified by pix_en so each fires once per pixel step regardless of
    // enable ratio, and suppressed while rst is held so no strobe appears during reset.
    line_end_d    = bus.pix_en && !rst && (hc == H_LAST_C);
    frame_start_d = bus.pix_en && !rst && (hc == '0) && (vc == '0);
  end

  assign bus.hc = hc;
  assign bus.vc = vc;

`ifdef VGA_OUT_REG_EN
  logic             hs_q;
  logic             vs_q;
  logic             vid_q;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             line_end_q;
  logic             frame_start_q;

  // Levels capture the decode of the pixel being left, so they trail hc/vc by one pixel.
  // Strobes reload every clk so they are one clk wide even at low enable ratios.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q          <= HS_ON;
      vs_q          <= VS_ON;
      vid_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (bus.pix_en) begin
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        vid_q <= vid_d;
        x_q   <= x_d;
        y_q   <= y_d;
      end
      line_end_q    <= line_end_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.Hsync       = hs_q;
  assign bus.Vsync       = vs_q;
  assign bus.vidon       = vid_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_end    = line_end_q;
  assign bus.frame_start = frame_start_q;
`else
  assign bus.Hsync       = hs_d;
  assign bus.Vsync       = vs_d;
  assign bus.vidon       = vid_d;
  assign bus.x           = x_d;
  assign bus.y           = y_d;
  assign bus.line_end    = line_end_d;
  assign bus.frame_start = frame_start_d;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen using a small video mode.
// The reference model tracks the linear pixel index within a frame and derives every
// expected output from it with plain division/modulo arithmetic.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
  localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
  localparam int HPOL = 1, VPOL = 0;
  localparam int CW = 10;
  localparam int HT = HS + HBP + HA + HFP;   // 28
  localparam int VT = VS + VBP + VA + VFP;   // 17
  localparam int FRAME = HT * VT;            // 476
  localparam int HSTART = HS + HBP;
  localparam int VSTART = VS + VBP;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        vid;
    logic [31:0] x;
    logic [31:0] y;
    logic        le;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CNT_W(CW)) bus ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(HPOL), .V_POL(VPOL), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int   pos = 0;        // pixel index within the frame, 0..FRAME-1
  exp_t regq;           // registered-output image (used with VGA_OUT_REG_EN)
  bit   cur_rst = 1'b1;
  bit   cur_en  = 1'b0;
  int   vid_cnt = 0;
  int   fs_seen = 0;
  int   fs_model = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t pos=%0d)", tag, got, exp, $time, pos);
    end
  endtask

  function automatic exp_t decode(input int p);
    exp_t e;
    int h, v;
    h = p % HT;
    v = p / HT;
    e.hs  = (h < HS) ? HPOL[0] : !HPOL[0];
    e.vs  = (v < VS) ? VPOL[0] : !VPOL[0];
    e.vid = (h >= HSTART) && (h < HSTART + HA) && (v >= VSTART) && (v < VSTART + VA);
    e.x   = e.vid ? 32'(h - HSTART) : 32'd0;
    e.y   = e.vid ? 32'(v - VSTART) : 32'd0;
    e.le  = (h == HT - 1);
    e.fs  = (p == 0);
    return e;
  endfunction

  function automatic exp_t reset_val();
    exp_t e;
    e = '0;
    e.hs = HPOL[0];
    e.vs = VPOL[0];
    return e;
  endfunction

  // One clock: advance the model over the edge, drive new inputs, check at negedge.
  task automatic run_cycle(input bit r, input bit en);
    exp_t e;
    @(posedge clk);
    if (cur_rst) begin
      pos  = 0;
      regq = reset_val();
    end else if (cur_en) begin
      regq = decode(pos);
      pos  = (pos + 1) % FRAME;
    end else begin
      regq.le = 1'b0;
      regq.fs = 1'b0;
    end
    #1;
    rst        = r;
    bus.pix_en = en;
    cur_rst    = r;
    cur_en     = en;
    @(negedge clk);
`ifdef VGA_OUT_REG_EN
    e = regq;
`else
    e = decode(pos);
    e.le = e.le && cur_en && !cur_rst;
    e.fs = e.fs && cur_en && !cur_rst;
`endif
    check("hc",          32'(bus.hc),          32'(pos % HT));
    check("vc",          32'(bus.vc),          32'(pos / HT));
    check("Hsync",       32'(bus.Hsync),       32'(e.hs));
    check("Vsync",       32'(bus.Vsync),       32'(e.vs));
    check("vidon",       32'(bus.vidon),       32'(e.vid));
    check("x",           32'(bus.x),           e.x);
    check("y",           32'(bus.y),           e.y);
    check("line_end",    32'(bus.line_end),    32'(e.le));
    check("frame_start", 32'(bus.frame_start), 32'(e.fs));
    if (bus.vidon === 1'b1) vid_cnt++;
    if (bus.frame_start === 1'b1) fs_seen++;
    if (e.fs) fs_model++;
  endtask

  initial begin
    rst        = 1'b1;
    bus.pix_en = 1'b0;
    regq       = reset_val();

    // reset held with pix_en high: reset wins, no strobes
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);

    // two full frames at one pixel per clk; count active pixels
    vid_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) run_cycle(1'b0, 1'b1);
    check("vidon_per_2_frames", 32'(vid_cnt), 32'(2 * HA * VA));

    // one pixel every 4 clks for just over a frame
    for (int i = 0; i < 4 * FRAME + 8; i++) run_cycle(1'b0, (i % 4) == 0);

    // run to a mid-frame position, then reset there and release with enable low
    for (int i = 0; i < FRAME && pos != (6 * HT + 10); i++) run_cycle(1'b0, 1'b1);
    check("reached_mid_frame", 32'(pos), 32'(6 * HT + 10));
    run_cycle(1'b1, 1'b1);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b0);
    for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b1);

    // random enable ratio with occasional resets
    for (int i = 0; i < 3000; i++)
      run_cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0);

    check("frame_start_count", 32'(fs_seen), 32'(fs_model));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
